usr_burst_shift: RTL and testbench

Parametrised universal shift register with a multi-step burst controller. A single command can hold, parallel-load, logical-shift, rotate or arithmetic-shift the register by a programmable number of positions, one position per clock, with a busy/done handshake. It is the datapath shifter for serial converters and bit-manipulation labs. It sits between a command source (FSM or switch bank) and display/serial logic.

---
 rtl/usr_burst_shift_if.sv | 29 ++
 rtl/usr_burst_shift.sv | 112 +++++++++++
 tb/tb_usr_burst_shift.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/usr_burst_shift_if.sv
// Command/status bundle for usr_burst_shift; cap exists only when USR_SHIFT_CAPTURE_EN is defined.
interface usr_burst_shift_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             abort;
    logic [WIDTH-1:0] pin;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
`ifdef USR_SHIFT_CAPTURE_EN
    logic [WIDTH-1:0] cap;

    modport master (output start, mode, amount, abort, pin, sin,
                    input  q, sout, busy, done, cap);
    modport slave  (input  start, mode, amount, abort, pin, sin,
                    output q, sout, busy, done, cap);
`else
    modport master (output start, mode, amount, abort, pin, sin,
                    input  q, sout, busy, done);
    modport slave  (input  start, mode, amount, abort, pin, sin,
                    output q, sout, busy, done);
`endif
endinterface

// File: rtl/usr_burst_shift.sv
// Universal shift register with a one-step-per-clock burst controller, falling-edge clocked.
// Optional shifted-out bit capture register enabled by macro USR_SHIFT_CAPTURE_EN.
module usr_burst_shift #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    usr_burst_shift_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   w_step;
`ifdef USR_SHIFT_CAPTURE_EN
    logic [WIDTH-1:0] r_cap;
`endif

    function automatic logic f_is_shift(input logic [2:0] m);
        return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
    endfunction

    // Returns {out_bit, next_q} for one single-position step.
    function automatic logic [WIDTH:0] f_step(input logic [2:0] m,
                                              input logic [WIDTH-1:0] v,
                                              input logic s);
        case (m)
            3'd1:    return {v[WIDTH-1], v[WIDTH-2:0], s};
            3'd2:    return {v[0], s, v[WIDTH-1:1]};
            3'd4:    return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            3'd5:    return {v[0], v[0], v[WIDTH-1:1]};
            3'd6:    return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: return {1'b0, v};
        endcase
    endfunction

    assign w_step = f_step(r_mode, r_q, bus.sin);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef USR_SHIFT_CAPTURE_EN
            r_cap   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_cnt  <= bus.amount;
                        if (f_is_shift(bus.mode)) begin
`ifdef USR_SHIFT_CAPTURE_EN
                            r_cap <= '0;
`endif
                            if (bus.amount == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_busy  <= 1'b1;
                                r_state <= S_RUN;
                            end
                        end else begin
                            if (bus.mode == 3'd3)
                                r_q <= bus.pin;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Abort drops the remaining steps without a completion pulse.
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_q    <= w_step[WIDTH-1:0];
                        r_sout <= w_step[WIDTH];
`ifdef USR_SHIFT_CAPTURE_EN
                        r_cap  <= {r_cap[WIDTH-2:0], w_step[WIDTH]};
`endif
                        r_cnt  <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.q    = r_q;
    assign bus.sout = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
`ifdef USR_SHIFT_CAPTURE_EN
    assign bus.cap  = r_cap;
`endif
endmodule

// File: tb/tb_usr_burst_shift.sv
// Directed bench for usr_burst_shift: inputs driven and outputs sampled on the rising edge.
module tb_usr_burst_shift;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    usr_burst_shift_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_burst_shift #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a rising edge; returns at the rising edge after accept edge E0.
    task automatic go(input logic [2:0] m, input logic [CNT_W-1:0] a);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.amount = a;
        @(posedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 3'd0;
        bus.amount = '0;
        bus.abort  = 1'b0;
        bus.pin    = '0;
        bus.sin    = 1'b0;
        step(2);
        check("rst_q", bus.q, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sout", bus.sout, 0);
        reset = 1'b0;
        step(1);

        // Parallel load
        bus.pin = 8'hA5;
        go(3'd3, 0);
        check("load_q", bus.q, 8'hA5);
        check("load_done", bus.done, 1);
        check("load_busy", bus.busy, 0);
        step(1);
        check("load_done_clr", bus.done, 0);

        // Shift left 3 with sin=1
        bus.sin = 1'b1;
        go(3'd1, 3);
        check("shl_e0_q", bus.q, 8'hA5);
        check("shl_e0_busy", bus.busy, 1);
        step(1);
        check("shl_e1_q", bus.q, 8'h4B);
        step(1);
        check("shl_e2_q", bus.q, 8'h97);
        check("shl_e2_busy", bus.busy, 1);
        check("shl_e2_done", bus.done, 0);
        step(1);
        check("shl_e3_q", bus.q, 8'h2F);
        check("shl_e3_busy", bus.busy, 0);
        check("shl_e3_done", bus.done, 1);
        check("shl_e3_sout", bus.sout, 1);
`ifdef USR_SHIFT_CAPTURE_EN
        check("shl_cap", bus.cap, 8'h05);
`endif
        step(1);
        check("shl_done_clr", bus.done, 0);

        // Rotate right 4
        bus.pin = 8'hA5;
        go(3'd3, 0);
        step(1);
        go(3'd5, 4);
        step(3);
        check("rotr_e3_done", bus.done, 0);
        step(1);
        check("rotr_q", bus.q, 8'h5A);
        check("rotr_done", bus.done, 1);

        // Rotate left by full width
        go(3'd3, 0);
        step(1);
        go(3'd4, 8);
        step(8);
        check("rotl8_q", bus.q, 8'hA5);
        check("rotl8_done", bus.done, 1);

        // Zero-amount shift accepted on the edge done drops
        go(3'd1, 0);
        check("amt0_q", bus.q, 8'hA5);
        check("amt0_done", bus.done, 1);
        check("amt0_busy", bus.busy, 0);

        // Amounts beyond WIDTH
        go(3'd4, 9);
        step(9);
        check("rotl9_q", bus.q, 8'h4B);
        bus.sin = 1'b0;
        go(3'd2, 10);
        step(10);
        check("shr10_q", bus.q, 8'h00);

        // Arithmetic right
        bus.pin = 8'h90;
        go(3'd3, 0);
        go(3'd6, 2);
        step(1);
        check("asr_e1_q", bus.q, 8'hC8);
        step(1);
        check("asr_q", bus.q, 8'hE4);
        check("asr_sout", bus.sout, 0);
        check("asr_done", bus.done, 1);

        // Start while busy, then abort
        bus.pin = 8'hA5;
        go(3'd3, 0);
        bus.sin = 1'b0;
        go(3'd1, 5);
        bus.start = 1'b1;
        bus.mode  = 3'd3;
        bus.pin   = 8'hFF;
        step(1);
        bus.start = 1'b0;
        check("busy_start_q", bus.q, 8'h4A);
        check("busy_start_busy", bus.busy, 1);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check("abort_q", bus.q, 8'h4A);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sout", bus.sout, 1);
        step(1);
        check("abort_done_later", bus.done, 0);
        check("abort_q_later", bus.q, 8'h4A);

        // Abort in IDLE does not block a start
        bus.abort = 1'b1;
        bus.pin   = 8'h0F;
        go(3'd3, 0);
        bus.abort = 1'b0;
        check("idle_abort_q", bus.q, 8'h0F);
        check("idle_abort_done", bus.done, 1);

        // Asynchronous reset mid-burst
        bus.sin = 1'b1;
        go(3'd1, 5);
        step(1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_q", bus.q, 8'h00);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_sout", bus.sout, 0);
        @(posedge clk);
        reset   = 1'b0;
        bus.pin = 8'h3C;
        go(3'd3, 0);
        check("post_rst_q", bus.q, 8'h3C);
        check("post_rst_done", bus.done, 1);
        check("post_rst_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
